// File: rtl/race_sequencer.sv
// Race phase controller: sequences countdown, driving, pause, crash and finish,
// produces drive/speed-update enables and accumulates distance from ySpeed.
module race_sequencer #(
    parameter int TICK_DIV    = 5000000,
    parameter int COUNT_TICKS = 10,
    parameter int FINISH_DIST = 50000,
    parameter int CRASH_HOLD  = 20
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        pause,
    input  logic        crash,
    input  logic [6:0]  ySpeed,
    output logic        driveEnable,
    output logic        speedEnable,
    output logic [1:0]  countDigit,
    output logic [15:0] distance,
    output logic [2:0]  state
);

    localparam int TW = $clog2(TICK_DIV);
    localparam int SW = $clog2(COUNT_TICKS + 1);
    localparam int HW = $clog2(CRASH_HOLD + 1);
    localparam logic [16:0] FIN_LIMIT = 17'(FINISH_DIST);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_COUNTDOWN = 3'd1,
        S_DRIVE     = 3'd2,
        S_PAUSED    = 3'd3,
        S_CRASH     = 3'd4,
        S_FINISH    = 3'd5
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   tick_cnt_q, tick_cnt_d;
    logic [SW-1:0]   sub_cnt_q, sub_cnt_d;
    logic [HW-1:0]   hold_cnt_q, hold_cnt_d;
    logic [1:0]      digit_q, digit_d;
    logic [15:0]     dist_q, dist_d;
    logic            drive_en_q, drive_en_d;
    logic            speed_en_q, speed_en_d;

    logic            tick;
    logic [16:0]     dist_sum;
    logic [15:0]     dist_sat;

    // Free-running game-tick divider; only reset clears it, so tick phase is
    // independent of race state.
    assign tick       = (tick_cnt_q == TW'(TICK_DIV - 1));
    assign tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);

    assign dist_sum = {1'b0, dist_q} + {10'd0, ySpeed};
    assign dist_sat = dist_sum[16] ? 16'hFFFF : dist_sum[15:0];

    always_comb begin
        state_d    = state_q;
        sub_cnt_d  = sub_cnt_q;
        hold_cnt_d = hold_cnt_q;
        digit_d    = digit_q;
        dist_d     = dist_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_COUNTDOWN;
                    digit_d   = 2'd3;
                    sub_cnt_d = '0;
                    dist_d    = '0;
                end
            end
            S_COUNTDOWN: begin
                if (tick) begin
                    if (sub_cnt_q == SW'(COUNT_TICKS - 1)) begin
                        sub_cnt_d = '0;
                        if (digit_q <= 2'd1) begin
                            digit_d = 2'd0;
                            state_d = S_DRIVE;
                        end else begin
                            digit_d = digit_q - 2'd1;
                        end
                    end else begin
                        sub_cnt_d = sub_cnt_q + SW'(1);
                    end
                end
            end
            S_DRIVE: begin
                if (crash) begin
                    state_d    = S_CRASH;
                    hold_cnt_d = '0;
                end else if (pause) begin
                    state_d = S_PAUSED;
                end else if (tick) begin
                    dist_d = dist_sat;
                    if ({1'b0, dist_sat} >= FIN_LIMIT) begin
                        state_d = S_FINISH;
                    end
                end
            end
            S_PAUSED: begin
                if (crash) begin
                    state_d    = S_CRASH;
                    hold_cnt_d = '0;
                end else if (!pause) begin
                    state_d = S_DRIVE;
                end
            end
            S_CRASH: begin
                if (tick) begin
                    if (hold_cnt_q == HW'(CRASH_HOLD - 1)) begin
                        state_d    = S_COUNTDOWN;
                        hold_cnt_d = '0;
                        digit_d    = 2'd3;
                        sub_cnt_d  = '0;
                        dist_d     = '0;
                    end else begin
                        hold_cnt_d = hold_cnt_q + HW'(1);
                    end
                end
            end
            S_FINISH: begin
                if (start) begin
                    state_d   = S_COUNTDOWN;
                    digit_d   = 2'd3;
                    sub_cnt_d = '0;
                    dist_d    = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Enables are registered from the next state so they move with state.
    assign drive_en_d = (state_d == S_DRIVE) || (state_d == S_PAUSED);
    assign speed_en_d = tick && (state_q == S_DRIVE) && !crash && !pause;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            tick_cnt_q <= '0;
            sub_cnt_q  <= '0;
            hold_cnt_q <= '0;
            digit_q    <= 2'd3;
            dist_q     <= '0;
            drive_en_q <= 1'b0;
            speed_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            sub_cnt_q  <= sub_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            digit_q    <= digit_d;
            dist_q     <= dist_d;
            drive_en_q <= drive_en_d;
            speed_en_q <= speed_en_d;
        end
    end

    assign driveEnable = drive_en_q;
    assign speedEnable = speed_en_q;
    assign countDigit  = digit_q;
    assign distance    = dist_q;
    assign state       = state_q;

endmodule
